// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: radix-2^2 SDF stage control (butterfly ctrl, -j, twiddle addr, fill tracking); ports i_clk,i_rst,i_valid,i_sop -> o_bf1_ctrl,o_bf2_ctrl,o_negj,o_tw_addr,o_valid,o_err; SDF_STAGE_CTRL_TWIDDLE_EN enables the twiddle address
module sdf_stage_ctrl #(
  parameter int N_LOG2 = 6,
  parameter int STAGE  = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_sop,
  output logic              o_bf1_ctrl,
  output logic              o_bf2_ctrl,
  output logic              o_negj,
  output logic [N_LOG2-1:0] o_tw_addr,
  output logic              o_valid,
  output logic              o_err
);
  localparam int P = N_LOG2 - 1 - 2 * STAGE;
  localparam int FILL_LEN = ((1 << N_LOG2) >> (2 * STAGE + 1)) + ((1 << N_LOG2) >> (2 * STAGE + 2));
  localparam logic [N_LOG2-1:0] FILL_LAST = N_LOG2'(FILL_LEN - 1);
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  state_t r_state, w_state_nx;
  logic [N_LOG2-1:0] r_cnt, w_k, w_tw;
  logic w_acc, w_err;
  always_comb begin
    w_k = i_sop ? '0 : r_cnt;
    w_acc = i_valid & (i_sop | (r_state != IDLE));
    w_err = i_valid & i_sop & (r_state != IDLE) & (r_cnt != '0);
    w_state_nx = (r_state == IDLE && i_valid && i_sop) ? FILL :
                 (r_state == FILL && i_valid && w_k == FILL_LAST) ? RUN : r_state;
  end
`ifdef SDF_STAGE_CTRL_TWIDDLE_EN
  localparam logic [N_LOG2-1:0] LMASK = N_LOG2'((1 << (P - 1)) - 1);
  logic [N_LOG2-1:0] w_low;
  // m is the bit-reversed {k[p],k[p-1]}, so the product is a shift plus an add
  always_comb begin
    w_low = w_k & LMASK;
    w_tw = (w_k[P-1] ? (w_low << 1) : '0) + (w_k[P] ? w_low : '0);
  end
`else
  assign w_tw = '0;
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      o_bf1_ctrl <= 1'b0;
      o_bf2_ctrl <= 1'b0;
      o_negj <= 1'b0;
      o_tw_addr <= '0;
      o_valid <= 1'b0;
      o_err <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      o_err <= w_err;
      o_valid <= i_valid & (w_state_nx == RUN);
      if (w_acc) begin
        r_cnt <= w_k + 1'b1;
        o_bf1_ctrl <= w_k[P];
        o_bf2_ctrl <= w_k[P-1];
        o_negj <= w_k[P] & ~w_k[P-1];
        o_tw_addr <= w_tw;
      end
    end
  end
endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb_sdf_stage_ctrl: directed self-checking bench for sdf_stage_ctrl at N_LOG2=4, STAGE=0
module tb_sdf_stage_ctrl;
  logic i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0, i_sop = 1'b0;
  logic o_bf1_ctrl, o_bf2_ctrl, o_negj, o_valid, o_err;
  logic [3:0] o_tw_addr;
  int checks = 0, failures = 0;
`ifdef SDF_STAGE_CTRL_TWIDDLE_EN
  localparam int TW5 = 2, TW14 = 6;
`else
  localparam int TW5 = 0, TW14 = 0;
`endif
  sdf_stage_ctrl #(.N_LOG2(4), .STAGE(0)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_sop(i_sop),
    .o_bf1_ctrl(o_bf1_ctrl), .o_bf2_ctrl(o_bf2_ctrl), .o_negj(o_negj),
    .o_tw_addr(o_tw_addr), .o_valid(o_valid), .o_err(o_err)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic v, input logic s);
    i_valid = v;
    i_sop = s;
    @(posedge i_clk);
    #1;
  endtask
  task automatic chk_k(input string tag, input int k, input int ov, input int err);
    logic [3:0] kb;
    kb = k[3:0];
    chk({tag, "_bf1"}, int'(o_bf1_ctrl), int'(kb[3]));
    chk({tag, "_bf2"}, int'(o_bf2_ctrl), int'(kb[2]));
    chk({tag, "_negj"}, int'(o_negj), int'(kb[3] & ~kb[2]));
    chk({tag, "_valid"}, int'(o_valid), ov);
    chk({tag, "_err"}, int'(o_err), err);
  endtask
  task automatic chk_zero(input string tag);
    chk_k(tag, 0, 0, 0);
    chk({tag, "_tw"}, int'(o_tw_addr), 0);
  endtask
  initial begin
    step(0, 0);
    step(1, 1);
    chk_zero("reset");
    i_rst = 1'b0;
    step(1, 0);
    chk_zero("idle_ignore1");
    step(1, 0);
    chk_zero("idle_ignore2");
    // full frame: fill completes on the 12th valid
    for (int i = 0; i < 16; i++) begin
      step(1, i == 0);
      chk_k("frame", i, int'(i >= 11), 0);
      if (i == 5) chk("tw_k5", int'(o_tw_addr), TW5);
      if (i == 14) chk("tw_k14", int'(o_tw_addr), TW14);
    end
    // sop exactly on the wrap, then valid toggling every cycle
    step(1, 1);
    chk_k("wrap_sop", 0, 1, 0);
    for (int i = 1; i < 16; i++) begin
      step(0, 0);
      chk_k("gap", i - 1, 0, 0);
      step(1, 0);
      chk_k("toggle", i, 1, 0);
    end
    step(0, 0);
    chk_k("gap_end", 15, 0, 0);
    // misaligned sop at sample 5
    for (int i = 0; i < 5; i++) begin
      step(1, i == 0);
      chk_k("pre_err", i, 1, 0);
    end
    step(1, 1);
    chk_k("err_sop", 0, 1, 1);
    step(1, 0);
    chk_k("after_err", 1, 1, 0);
    chk("after_err_tw", int'(o_tw_addr), 0);
    for (int i = 2; i < 9; i++) begin
      step(1, 0);
      chk_k("pre_rst", i, 1, 0);
    end
    // reset at sample 9, then refill from a fresh sop
    i_rst = 1'b1;
    step(1, 0);
    chk_zero("mid_rst");
    i_rst = 1'b0;
    step(1, 0);
    chk_zero("post_rst_idle");
    for (int i = 0; i < 16; i++) begin
      step(1, i == 0);
      chk_k("refill", i, int'(i >= 11), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sdf_stage_ctrl.md
SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

Interface
REQ-001 SHALL have parameter N_LOG2, default 6, meaning log2 of the FFT size N (N = 2^N_LOG2, N_LOG2 >= 2).
REQ-002 SHALL have parameter STAGE, default 0, meaning the radix-2^2 stage index s, where 0 <= s < N_LOG2/2; it sets D1 = N>>(2s+1) and D2 = N>>(2s+2).
REQ-003 SHALL have port i_clk, input, width 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst, input, width 1, meaning the reset; reset is synchronous and active-high.
REQ-005 SHALL have port i_valid, input, width 1, meaning one complex sample enters the stage this cycle.
REQ-006 SHALL have port i_sop, input, width 1, meaning the start of a frame; it is qualified by i_valid.
REQ-007 SHALL have port o_bf1_ctrl, output, width 1, meaning the control input of the first butterfly (0 = bypass into the delay line, 1 = add/subtract).
REQ-008 SHALL have port o_bf2_ctrl, output, width 1, meaning the control input of the second butterfly.
REQ-009 SHALL have port o_negj, output, width 1, meaning apply the trivial -j rotation ahead of the second butterfly.
REQ-010 SHALL have port o_tw_addr, output, width N_LOG2, meaning the twiddle ROM address for the stage-output multiplier.
REQ-011 SHALL have port o_valid, output, width 1, meaning the stage output sample is valid.
REQ-012 SHALL have port o_err, output, width 1, meaning a one-cycle pulse flagging a misaligned i_sop.

Function
REQ-013 SHALL keep an N_LOG2-bit sample counter cnt that increments by 1 on each i_valid and wraps from N-1 to 0.
REQ-014 SHALL load cnt with 1 when i_valid and i_sop are high together, so the sop sample is treated as index 0.
REQ-015 SHALL register all outputs, so they reflect the sample accepted in the previous cycle (latency 1); outputs SHALL hold their values while i_valid is low.
REQ-016 SHALL compute the control bits from the sample index k = (i_sop ? 0 : cnt), using p = N_LOG2-1-2s:
- o_bf1_ctrl = k[p]
- o_bf2_ctrl = k[p-1]
- o_negj = k[p] & ~k[p-1]
REQ-017 SHALL implement a state machine with states IDLE, FILL and RUN:
- IDLE -> FILL on i_valid&i_sop.
- FILL -> RUN once D1+D2 valid samples have been accepted, counting the sop sample.
- RUN holds until reset.
REQ-018 SHALL drive o_valid low in IDLE and FILL, and equal to the registered i_valid in RUN.
REQ-019 SHALL ignore i_valid without i_sop while in IDLE: cnt stays 0 and the control outputs stay 0.
REQ-020 SHALL handle i_sop arriving with cnt != 0 in FILL or RUN as follows: pulse o_err for 1 cycle, realign cnt per REQ-014, and leave the state unchanged.
REQ-021 SHALL NOT pulse o_err for an i_sop that arrives exactly on the wrap (cnt == 0).

Reset
REQ-022 SHALL, while i_rst is high, set state = IDLE, cnt = 0, and all outputs to 0; i_rst SHALL take priority over i_valid and i_sop.
REQ-023 SHALL, when reset is applied mid-frame, discard the partial frame, so that the next i_sop restarts FILL.

Configuration
REQ-024 SHALL, with SDF_STAGE_CTRL_TWIDDLE_EN defined, set o_tw_addr = (k mod 2^(p-1)) * m, truncated to N_LOG2 bits, where m = 0, 2, 1, 3 for {k[p],k[p-1]} = 00, 01, 10, 11 respectively.
REQ-025 SHALL, with SDF_STAGE_CTRL_TWIDDLE_EN undefined, tie o_tw_addr to 0 and include no multiplier logic; this is the setting for the last stage.

Verification
REQ-026 SHALL pass this scenario (N_LOG2=4, STAGE=0): reset, then 16 consecutive valids with sop on the first -> o_bf1_ctrl is 0 for samples 0-7 and 1 for samples 8-15; o_bf2_ctrl toggles every 4 samples; o_valid first rises on the cycle after the 12th valid.
REQ-027 SHALL pass this scenario (N_LOG2=4, STAGE=0): valids with i_valid toggling every cycle -> the control outputs advance only on valid samples and match REQ-026 per sample index.
REQ-028 SHALL pass this scenario (N_LOG2=4, STAGE=0): sop injected at sample 5 of a frame -> o_err high for 1 cycle, and the next sample uses k=1.
REQ-029 SHALL pass this scenario (N_LOG2=4, STAGE=0): i_rst asserted at sample 9 -> all outputs 0 on the next cycle; a later sop restarts FILL, and o_valid stays low for 12 samples.
REQ-030 SHALL pass this scenario (N_LOG2=4, STAGE=0, TWIDDLE_EN defined): k=5 ({k3,k2}=01, low bits 1) -> o_tw_addr=2; k=14 -> o_tw_addr=6.
